// File: rtl/cdb_pkg.sv
// Shared CDB arbiter types: default ROB geometry, broadcast bus struct and the ROB age helper.
package cdb_pkg;

  localparam int unsigned ROB_DEPTH     = 32;
  localparam int unsigned TAG_W         = $clog2(ROB_DEPTH);

  // Widest supported tag (ROB_DEPTH up to 256); the age helper also has room for the rdptr wrap bit.
  localparam int unsigned CDB_TAG_W_MAX = 8;
  localparam int unsigned CDB_AGE_W     = CDB_TAG_W_MAX + 1;

  typedef struct packed {
    logic                     val;
    logic [CDB_TAG_W_MAX-1:0] robtag;
    logic [31:0]              swaddr;
  } cdb_bus_t;

  // Distance of a tag from the ROB head, wrapped to tag_w bits.
  function automatic logic [CDB_AGE_W-1:0] cdb_age(
    input logic [CDB_AGE_W-1:0] tag,
    input logic [CDB_AGE_W-1:0] rdptr,
    input int unsigned          tag_w
  );
    logic [CDB_AGE_W-1:0] mask;
    mask = '0;
    for (int unsigned b = 0; b < CDB_AGE_W; b++) begin
      if (b < tag_w) mask[b] = 1'b1;
    end
    return (tag - rdptr) & mask;
  endfunction

endpackage

// File: rtl/cdb_rr_select.sv
// Round-robin one-hot grant: first set request at or above ptr_i, wrapping around.
module cdb_rr_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  import cdb_pkg::*;

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: squashes results younger than a mispredicted branch and registers one broadcast per cycle.
// Define CDB_ARB_AGE_PRIO_EN to grant the oldest eligible result instead of round-robin.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ROB_DEPTH = cdb_pkg::ROB_DEPTH,
  localparam int unsigned TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [NUM_REQ-1:0]            fu_req,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] fu_robtag,
  input  logic [NUM_REQ-1:0][31:0]      fu_data,
  output logic [NUM_REQ-1:0]            fu_ack,
  input  logic [TAG_W:0]                rob_rdptr,
  input  logic                          cdb_flush,
  input  logic [TAG_W-1:0]              cfc_robtag,
  output logic                          cdb_val,
  output logic [TAG_W-1:0]              cdb_robtag,
  output logic [31:0]                   cdb_swaddr
);
  import cdb_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [CDB_AGE_W-1:0]              cfc_age;
  logic [NUM_REQ-1:0][CDB_AGE_W-1:0] req_age;
  logic [NUM_REQ-1:0]                squash;
  logic [NUM_REQ-1:0]                elig;
  logic [NUM_REQ-1:0]                gnt;
  logic                              gnt_any;
  logic [PTR_W-1:0]                  gnt_idx;
  cdb_bus_t                          bus_q, bus_d;

  always_comb begin
    req_age = '0;
    squash  = '0;
    cfc_age = cdb_age(CDB_AGE_W'(cfc_robtag), CDB_AGE_W'(rob_rdptr), TAG_W);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_age[i] = cdb_age(CDB_AGE_W'(fu_robtag[i]), CDB_AGE_W'(rob_rdptr), TAG_W);
      squash[i]  = cdb_flush & fu_req[i] & (req_age[i] > cfc_age);
    end
    elig = fu_req & ~squash;
  end

`ifdef CDB_ARB_AGE_PRIO_EN
  logic [CDB_AGE_W-1:0] best_age;
  logic [PTR_W-1:0]     best_idx;
  logic                 found;

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    gnt      = '0;
    best_age = '1;
    best_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (elig[i] && (!found || (req_age[i] < best_age))) begin
        found    = 1'b1;
        best_age = req_age[i];
        best_idx = PTR_W'(i);
      end
    end
    if (found) gnt[best_idx] = 1'b1;
  end
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  cdb_rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign gnt_any = |gnt;

  // A squashed registered broadcast can only stay valid through a fresh grant, which overwrites it.
  always_comb begin
    bus_d     = bus_q;
    bus_d.val = gnt_any;
    if (gnt_any) begin
      bus_d.robtag = CDB_TAG_W_MAX'(fu_robtag[gnt_idx]);
      bus_d.swaddr = fu_data[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) bus_q <= '0;
    else        bus_q <= bus_d;
  end

  assign fu_ack     = rst_b ? (gnt | squash) : '0;
  assign cdb_val    = bus_q.val;
  assign cdb_robtag = TAG_W'(bus_q.robtag);
  assign cdb_swaddr = bus_q.swaddr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic against an arithmetic reference model.
module tb_cdb_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned TW    = 5;

  logic                   clk = 1'b0;
  logic                   rst_b;
  logic [N-1:0]           fu_req;
  logic [N-1:0][TW-1:0]   fu_robtag;
  logic [N-1:0][31:0]     fu_data;
  logic [N-1:0]           fu_ack;
  logic [TW:0]            rob_rdptr;
  logic                   cdb_flush;
  logic [TW-1:0]          cfc_robtag;
  logic                   cdb_val;
  logic [TW-1:0]          cdb_robtag;
  logic [31:0]            cdb_swaddr;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ   (N),
    .ROB_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .fu_req     (fu_req),
    .fu_robtag  (fu_robtag),
    .fu_data    (fu_data),
    .fu_ack     (fu_ack),
    .rob_rdptr  (rob_rdptr),
    .cdb_flush  (cdb_flush),
    .cfc_robtag (cfc_robtag),
    .cdb_val    (cdb_val),
    .cdb_robtag (cdb_robtag),
    .cdb_swaddr (cdb_swaddr)
  );

  typedef struct packed {
    logic          val;
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } bc_t;

  logic [N-1:0] ack_q[$];
  bc_t          bc_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  bit           pend[N];
  int unsigned  ftag[N];
  logic [31:0]  fdat[N];
  int unsigned  m_rr;
  bc_t          m_last;
  int unsigned  cur_rd, cur_cfc;
  bit           cur_flush;
  bit           want_rst_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned age_of(input int unsigned t, input int unsigned rd);
    return (t + DEPTH - (rd % DEPTH)) % DEPTH;
  endfunction

  task automatic set_fu(input int i, input int unsigned tag, input logic [31:0] data);
    pend[i] = 1'b1;
    ftag[i] = tag;
    fdat[i] = data;
  endtask

  // One cycle: drive at the falling edge, predict acks and the next broadcast, retire acked FUs.
  task automatic do_cycle();
    logic [N-1:0] sq, ack;
    int           winner;
    bc_t          nb;
    @(negedge clk);
    rst_b = want_rst_n;
    for (int i = 0; i < N; i++) begin
      fu_req[i]    = pend[i];
      fu_robtag[i] = TW'(ftag[i]);
      fu_data[i]   = fdat[i];
    end
    rob_rdptr  = (TW+1)'(cur_rd);
    cdb_flush  = cur_flush;
    cfc_robtag = TW'(cur_cfc);
    if (!want_rst_n) begin
      ack    = '0;
      nb     = '0;
      m_rr   = 0;
      m_last = '0;
    end else begin
      winner = -1;
      sq     = '0;
      for (int i = 0; i < N; i++)
        sq[i] = cur_flush && pend[i] && (age_of(ftag[i], cur_rd) > age_of(cur_cfc, cur_rd));
`ifdef CDB_ARB_AGE_PRIO_EN
      for (int i = 0; i < N; i++)
        if (pend[i] && !sq[i])
          if (winner < 0 || age_of(ftag[i], cur_rd) < age_of(ftag[winner], cur_rd)) winner = i;
`else
      for (int k = 0; k < N; k++) begin
        int i;
        i = int'((m_rr + k) % N);
        if (winner < 0 && pend[i] && !sq[i]) winner = i;
      end
`endif
      ack    = sq;
      nb     = m_last;
      nb.val = 1'b0;
      if (winner >= 0) begin
        ack[winner] = 1'b1;
        nb.val      = 1'b1;
        nb.tag      = TW'(ftag[winner]);
        nb.data     = fdat[winner];
        m_rr        = (winner + 1) % N;
      end
      m_last = nb;
      for (int i = 0; i < N; i++) if (ack[i]) pend[i] = 1'b0;
    end
    ack_q.push_back(ack);
    bc_q.push_back(nb);
  endtask

  initial begin : monitor
    logic [N-1:0] ea;
    bc_t          eb;
    forever begin
      @(negedge clk);
      #2;
      if (ack_q.size() > 0) begin
        ea = ack_q.pop_front();
        chk("fu_ack", 64'(fu_ack), 64'(ea));
      end
      @(posedge clk);
      #1;
      if (bc_q.size() > 0) begin
        eb = bc_q.pop_front();
        chk("cdb_val", 64'(cdb_val), 64'(eb.val));
        chk("cdb_robtag", 64'(cdb_robtag), 64'(eb.tag));
        chk("cdb_swaddr", 64'(cdb_swaddr), 64'(eb.data));
      end else begin
        chk("cdb_val_unexpected", 64'(cdb_val), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_b      = 1'b0;
    want_rst_n = 1'b0;
    fu_req     = '0;
    fu_robtag  = '0;
    fu_data    = '0;
    rob_rdptr  = '0;
    cdb_flush  = 1'b0;
    cfc_robtag = '0;
    cur_rd     = 0;
    cur_cfc    = 0;
    cur_flush  = 1'b0;
    m_rr       = 0;
    m_last     = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      ftag[i] = 0;
      fdat[i] = '0;
    end
    repeat (3) do_cycle();
    want_rst_n = 1'b1;

    // Four held requests after reset: served 0,1,2,3 back to back.
    set_fu(0, 3, 32'hA000_0003);
    set_fu(1, 7, 32'hA000_0007);
    set_fu(2, 9, 32'hA000_0009);
    set_fu(3, 12, 32'hA000_000C);
    repeat (5) do_cycle();

    // Flush at head 28, branch 30: tags 31 and 2 squashed, 29 survives.
    cur_rd = 28; cur_flush = 1'b1; cur_cfc = 30;
    set_fu(0, 31, 32'hB000_001F);
    set_fu(1, 2, 32'hB000_0002);
    set_fu(2, 29, 32'hB000_001D);
    do_cycle();
    cur_flush = 1'b0;
    do_cycle();

    // Registered tag 5 then a flush at branch 4.
    cur_rd = 0;
    set_fu(1, 5, 32'hC000_0005);
    do_cycle();
    cur_flush = 1'b1; cur_cfc = 4;
    do_cycle();
    cur_flush = 1'b0;
    do_cycle();

    // Branch tag equal to the requester's tag is not squashed.
    cur_flush = 1'b1; cur_cfc = 10;
    set_fu(2, 10, 32'hD000_000A);
    do_cycle();
    cur_flush = 1'b0;
    do_cycle();

    // Reset asserted mid-cycle while a broadcast is valid.
    for (int i = 0; i < N; i++) set_fu(i, i + 1, 32'hE000_0000 + 32'(i));
    do_cycle();
    @(posedge clk);
    #3;
    rst_b      = 1'b0;
    want_rst_n = 1'b0;
    #1;
    chk("reset_cdb_val", 64'(cdb_val), 64'd0);
    chk("reset_cdb_robtag", 64'(cdb_robtag), 64'd0);
    chk("reset_cdb_swaddr", 64'(cdb_swaddr), 64'd0);
    chk("reset_fu_ack", 64'(fu_ack), 64'd0);
    repeat (2) do_cycle();
    want_rst_n = 1'b1;
    repeat (4) do_cycle();

`ifdef CDB_ARB_AGE_PRIO_EN
    cur_rd = 30;
    set_fu(0, 1, 32'hF000_0001);
    set_fu(3, 31, 32'hF000_001F);
    repeat (3) do_cycle();
`endif

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(9) < 6) set_fu(i, $urandom_range(DEPTH - 1), $urandom);
      cur_rd     = $urandom_range(2 * DEPTH - 1);
      cur_flush  = ($urandom_range(4) == 0);
      cur_cfc    = $urandom_range(DEPTH - 1);
      want_rst_n = ($urandom_range(79) != 0);
      do_cycle();
    end

    want_rst_n = 1'b1;
    cur_flush  = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (2) do_cycle();
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(bc_q.size() + ack_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
